// File: rtl/leaf_packer_if.sv
// Beat-in / word-out bus for leaf_packer.
// A beat transfers on a rising edge where in_valid && in_ready; the source holds
// in_data/in_last stable while in_valid is high and in_ready is low. On the output
// side, out_en permits one pop per cycle and packet_valid qualifies packet_out.
interface leaf_packer_if #(
  parameter int WIDTH    = 32,
  parameter int IN_WIDTH = 8
);
  logic [IN_WIDTH-1:0] in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic                out_en;
  logic [WIDTH-1:0]    packet_out;
  logic                packet_valid;

  modport master (
    output in_data, in_valid, in_last, out_en,
    input  in_ready, packet_out, packet_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_en,
    output in_ready, packet_out, packet_valid
  );
endinterface

// File: rtl/leaf_packer.sv
// Packs IN_WIDTH beats little-endian into WIDTH-bit words, buffers them in a DEPTH-entry
// FIFO and emits one word per cycle. Optional counters under LEAF_PACKER_STATS_EN.
module leaf_packer #(
  parameter int WIDTH    = 32,
  parameter int IN_WIDTH = 8,
  parameter int DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  leaf_packer_if.slave  bus
`ifdef LEAF_PACKER_STATS_EN
  ,
  output logic [15:0]   words_out,
  output logic [15:0]   stall_cycles
`endif
);
  localparam int BEATS = WIDTH / IN_WIDTH;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (((WIDTH % IN_WIDTH) != 0) || (BEATS < 2)) begin : g_bad_width
    $error("leaf_packer: WIDTH must be a multiple (>= 2x) of IN_WIDTH");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("leaf_packer: DEPTH must be a power of two >= 2");
  end

  logic [IDX_W-1:0] r_beat_idx;
  logic [WIDTH-1:0] r_asm;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_packet_out;
  logic             r_packet_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_complete;
  logic             w_pop;
  logic [WIDTH-1:0] w_word;

  // in_ready depends only on registered count, never on out_en.
  assign w_in_ready = (r_count != CNT_W'(DEPTH));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_complete = w_accept && (bus.in_last || (r_beat_idx == IDX_W'(BEATS - 1)));
  assign w_pop      = bus.out_en && (r_count != '0);

  always_comb begin
    w_word = r_asm;
    w_word[r_beat_idx*IN_WIDTH +: IN_WIDTH] = bus.in_data;
  end

  // Clearing on completion keeps lanes above a short frame's last beat at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_idx <= '0;
      r_asm      <= '0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_beat_idx <= '0;
        r_asm      <= '0;
      end else begin
        r_beat_idx <= r_beat_idx + 1'b1;
        r_asm      <= w_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_complete) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_complete, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output is driven to zero whenever no word is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_packet_out   <= '0;
      r_packet_valid <= 1'b0;
    end else if (w_pop) begin
      r_packet_out   <= r_mem[r_rd_ptr];
      r_packet_valid <= 1'b1;
    end else begin
      r_packet_out   <= '0;
      r_packet_valid <= 1'b0;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.packet_out   = r_packet_out;
  assign bus.packet_valid = r_packet_valid;

`ifdef LEAF_PACKER_STATS_EN
  logic [15:0] r_words_out;
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words_out    <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (r_packet_valid && (r_words_out != 16'hFFFF))
        r_words_out <= r_words_out + 16'd1;
      if (bus.in_valid && !w_in_ready && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign words_out    = r_words_out;
  assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_leaf_packer.sv
// Self-checking bench for leaf_packer: directed scenarios plus randomized frames
// against a frame-level reference model and an expected-word queue.
module tb_leaf_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  leaf_packer_if #(.WIDTH(32), .IN_WIDTH(8)) bus ();

`ifdef LEAF_PACKER_STATS_EN
  logic [15:0] words_out;
  logic [15:0] stall_cycles;
`endif

  leaf_packer #(.WIDTH(32), .IN_WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef LEAF_PACKER_STATS_EN
    ,
    .words_out    (words_out),
    .stall_cycles (stall_cycles)
`endif
  );

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_words = 0;
  bit rand_out_en = 0;
  bit mon_en = 0;

  // Monitor: every valid word must be the next expected one; idle cycles must be zero.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (bus.packet_valid === 1'b1) begin
        n_words++;
        n_checks++;
        if (exp_q.size() == 0)
          $display("FAIL monitor_unexpected: got %h required no word", bus.packet_out);
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (bus.packet_out !== e)
            $display("FAIL monitor_order: got %h required %h", bus.packet_out, e);
          else n_pass++;
        end
      end else begin
        n_checks++;
        if (bus.packet_valid !== 1'b0 || bus.packet_out !== 32'h0)
          $display("FAIL monitor_idle: got valid=%b out=%h required 0/0",
                   bus.packet_valid, bus.packet_out);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_out_en) bus.out_en = 1'($urandom_range(0, 1));
  endtask

  task automatic deassert();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  // Holds the beat until accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic last);
    int waited;
    waited = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    n_checks++;
    if (waited >= 200) $display("FAIL beat_timeout: in_ready stuck at %b required 1", bus.in_ready);
    else n_pass++;
    tick();
  endtask

  // Reference model: a frame of nb beats yields the low nb bytes of data, upper bytes zero.
  task automatic send_word(input logic [31:0] data, input int nb, input bit force_last, input int gap);
    logic [31:0] exp;
    exp = 32'h0;
    for (int i = 0; i < nb; i++) begin
      logic l;
      l = (i == nb - 1) && (nb < 4 || force_last);
      exp = exp | ({24'h0, data[8*i +: 8]} << (8 * i));
      if (i == nb - 1) exp_q.push_back(exp);
      send_beat(data[8*i +: 8], l);
      if (gap > 0 && i != nb - 1) begin
        deassert();
        repeat (gap) tick();
      end
    end
    deassert();
  endtask

  task automatic drain();
    bus.out_en = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL drain_empty: got %0d words left required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    deassert();
    bus.out_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_words = 0;
    tick();
    n_checks++;
    if (bus.packet_out !== 32'h0 || bus.packet_valid !== 1'b0)
      $display("FAIL reset_out: got %h/%b required 0/0", bus.packet_out, bus.packet_valid);
    else n_pass++;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", bus.in_ready);
    else n_pass++;
`ifdef LEAF_PACKER_STATS_EN
    n_checks++;
    if (words_out !== 16'h0 || stall_cycles !== 16'h0)
      $display("FAIL reset_stats: got %h/%h required 0/0", words_out, stall_cycles);
    else n_pass++;
`endif
    mon_en = 1;
  endtask

  task automatic test_full_word();
    bus.out_en = 1'b1;
    exp_q.push_back(32'h44332211);
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b0);
    deassert();
    n_checks++;
    if (bus.packet_valid !== 1'b0) $display("FAIL full_word_early: got valid=%b required 0", bus.packet_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.packet_valid !== 1'b1 || bus.packet_out !== 32'h44332211)
      $display("FAIL full_word: got %h/%b required 44332211/1", bus.packet_out, bus.packet_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.packet_valid !== 1'b0 || bus.packet_out !== 32'h0)
      $display("FAIL full_word_after: got %h/%b required 0/0", bus.packet_out, bus.packet_valid);
    else n_pass++;
    drain();
  endtask

  task automatic test_partial_flush();
    bus.out_en = 1'b1;
    exp_q.push_back(32'h0000BBAA);
    send_beat(8'hAA, 1'b0);
    deassert();
    bus.in_last = 1'b1;
    tick();
    bus.in_last = 1'b0;
    send_beat(8'hBB, 1'b1);
    deassert();
    tick();
    n_checks++;
    if (bus.packet_valid !== 1'b1 || bus.packet_out !== 32'h0000BBAA)
      $display("FAIL partial_flush: got %h/%b required 0000bbaa/1", bus.packet_out, bus.packet_valid);
    else n_pass++;
    send_word(32'h04030201, 4, 1'b0, 0);
    tick();
    n_checks++;
    if (bus.packet_valid !== 1'b1 || bus.packet_out !== 32'h04030201)
      $display("FAIL partial_next_word: got %h/%b required 04030201/1", bus.packet_out, bus.packet_valid);
    else n_pass++;
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] w [4];
    logic [15:0] stall0;
    bus.out_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w[k] = $urandom;
      send_word(w[k], 4, 1'b0, 0);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL full_ready: got %b required 0", bus.in_ready);
    else n_pass++;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hE7;
    bus.in_last  = 1'b1;
    exp_q.push_back(32'h000000E7);
`ifdef LEAF_PACKER_STATS_EN
    stall0 = stall_cycles;
`else
    stall0 = 16'h0;
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.in_ready !== 1'b0) $display("FAIL stall_ready_%0d: got %b required 0", k, bus.in_ready);
      else n_pass++;
    end
    bus.out_en = 1'b1;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL ready_after_pop: got %b required 1", bus.in_ready);
    else n_pass++;
    n_checks++;
    if (bus.packet_valid !== 1'b1 || bus.packet_out !== w[0])
      $display("FAIL first_pop: got %h/%b required %h/1", bus.packet_out, bus.packet_valid, w[0]);
    else n_pass++;
    tick();
    deassert();
`ifdef LEAF_PACKER_STATS_EN
    n_checks++;
    if (stall_cycles - stall0 !== 16'd4)
      $display("FAIL stall_count: got %0d required 4", stall_cycles - stall0);
    else n_pass++;
`else
    if (stall0 != 16'h0) $display("stall baseline %h", stall0);
`endif
    drain();
  endtask

  task automatic test_simultaneous();
    logic [31:0] a, b, c;
    int n_valid;
    a = $urandom;
    b = $urandom;
    c = $urandom;
    bus.out_en = 1'b0;
    send_word(a, 4, 1'b0, 0);
    send_word(b, 4, 1'b0, 0);
    exp_q.push_back(c);
    send_beat(c[7:0], 1'b0);
    send_beat(c[15:8], 1'b0);
    send_beat(c[23:16], 1'b0);
    bus.out_en = 1'b1;
    send_beat(c[31:24], 1'b0);
    deassert();
    n_checks++;
    if (bus.packet_valid !== 1'b1 || bus.packet_out !== a)
      $display("FAIL simul_pop: got %h/%b required %h/1", bus.packet_out, bus.packet_valid, a);
    else n_pass++;
    n_valid = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.packet_valid === 1'b1) n_valid++;
    end
    n_checks++;
    if (n_valid != 2) $display("FAIL simul_count: got %0d words left required 2", n_valid);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    bus.out_en = 1'b0;
    for (int k = 0; k < 3; k++) send_word($urandom, 4, 1'b0, 0);
    send_beat(8'hC1, 1'b0);
    send_beat(8'hC2, 1'b0);
    deassert();
    bus.out_en = 1'b1;
    tick();
    bus.out_en = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    n_words = 0;
    #2;
    n_checks++;
    if (bus.packet_out !== 32'h0 || bus.packet_valid !== 1'b0)
      $display("FAIL async_reset_out: got %h/%b required 0/0", bus.packet_out, bus.packet_valid);
    else n_pass++;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL async_reset_ready: got %b required 1", bus.in_ready);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    bus.out_en = 1'b1;
    send_word(32'h58575655, 4, 1'b0, 0);
    tick();
    n_checks++;
    if (bus.packet_valid !== 1'b1 || bus.packet_out !== 32'h58575655)
      $display("FAIL reset_next_word: got %h/%b required 58575655/1", bus.packet_out, bus.packet_valid);
    else n_pass++;
    drain();
  endtask

  task automatic test_random();
    rand_out_en = 1;
    for (int f = 0; f < 40; f++) begin
      send_word($urandom, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_out_en = 0;
    drain();
  endtask

  task automatic test_idle();
    bus.out_en = 1'b1;
    deassert();
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (bus.packet_valid !== 1'b0 || bus.packet_out !== 32'h0)
        $display("FAIL idle_%0d: got %h/%b required 0/0", k, bus.packet_out, bus.packet_valid);
      else n_pass++;
    end
`ifdef LEAF_PACKER_STATS_EN
    n_checks++;
    if (words_out !== 16'(n_words))
      $display("FAIL words_out: got %0d required %0d", words_out, n_words);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_flush();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_random();
    test_idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/leaf_packer.md
Name: leaf_packer

Overview:
- Upstream feeder for the leaf packet pipeline.
- Accepts narrow IN_WIDTH beats over a valid/ready handshake and assembles them little-endian into WIDTH-bit words.
- Buffers completed words in a DEPTH-entry FIFO and emits at most one word per cycle on packet_out.
- The downstream leaf stage samples every cycle, so idle cycles drive all-zero words.

Parameters:
- WIDTH, 32, output word width; must be an integer multiple of IN_WIDTH ($error at elaboration otherwise).
- IN_WIDTH, 8, input beat width; BEATS = WIDTH/IN_WIDTH, BEATS >= 2.
- DEPTH, 4, word FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  IN_WIDTH  input beat
- in_valid  input  1  beat valid
- in_last  input  1  final beat of frame; flush partial word
- in_ready  output  1  beat accepted when in_valid && in_ready
- out_en  input  1  downstream permits a word pop this cycle
- packet_out  output  WIDTH  assembled word; zero when not valid
- packet_valid  output  1  packet_out holds a real word this cycle

Behaviour:
- Single clock domain. Reset is asynchronous assert, active-low, and applies to every flop.
- Reset values:
  - packet_out = 0, packet_valid = 0.
  - FIFO count, read pointer, write pointer = 0.
  - beat_idx = 0; assembly register = 0.
- Reset mid-word discards the partial word and all buffered words.
- in_ready = (count != DEPTH).
  - Driven from registered count only; there is no combinational path from out_en.
  - in_ready = 1 after reset.
- Assembly:
  - An accepted beat is written to lanes [beat_idx*IN_WIDTH +: IN_WIDTH].
  - beat_idx increments per accepted beat.
- Word completion happens on an accepted beat with beat_idx == BEATS-1, or with in_last = 1.
  - The word is pushed into the FIFO on that edge.
  - Lanes not written in this word are zero; no stale data from the previous word.
  - beat_idx returns to 0 and the assembly register clears.
- in_last on the final lane is a single completion, not two.
- in_last with in_valid = 0 is ignored.
- in_valid = 0 holds beat_idx and the partial word indefinitely; there is no timeout.
- Pop rule, evaluated on registered count:
  - If out_en = 1 and count > 0: packet_out <= head word, packet_valid <= 1, read pointer advances.
  - Otherwise: packet_out <= 0, packet_valid <= 0.
- Latency: a word completed on edge T is first visible on packet_out after edge T+1, provided out_en = 1 at T+1. Minimum is 2 cycles from the final beat handshake.
- Simultaneous push and pop leaves count unchanged. A push into an empty FIFO is not popped on the same edge.
- Full: count == DEPTH gives in_ready = 0; in_data and in_valid are held by the source (standard valid/ready).
  - A pop while full frees a slot.
  - in_ready rises the following cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and never over/underflows.
- Output ordering is strict FIFO.

Optional Feature:
- Macro: LEAF_PACKER_STATS_EN.
- When defined, adds ports:
  - words_out  output  16  count of cycles with packet_valid = 1; saturates at 0xFFFF.
  - stall_cycles  output  16  count of cycles with in_valid = 1 && in_ready = 0; saturates at 0xFFFF.
  - Both reset to 0 on rst_n low.
- When undefined, the ports and counters are absent and the datapath is unchanged.

Test Plan:
- Full word:
  - Stimulus: WIDTH=32, IN_WIDTH=8, out_en=1; beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Response: packet_out = 0x44332211 with packet_valid = 1, exactly 2 cycles after the 0x44 handshake; 0 before and after.
- Partial flush:
  - Stimulus: beats 0xAA, then 0xBB with in_last = 1; followed by full word 0x01..0x04.
  - Response: packet_out = 0x0000BBAA, then 0x04030201. No residue of 0xAA/0xBB in the second word.
- Full FIFO backpressure:
  - Stimulus: out_en = 0; push 16 beats.
  - Response: count = 4 and in_ready = 0; the 17th beat stalls.
  - Then: out_en = 1 pops words in order on 4 consecutive cycles; in_ready = 1 the cycle after the first pop.
- Simultaneous push/pop:
  - Stimulus: count = 2, out_en = 1, final beat accepted on the same edge as a pop.
  - Response: count stays 2; next outputs in FIFO order.
- Reset mid-operation:
  - Stimulus: 2 beats of a word plus 2 buffered words; assert rst_n low for 1 cycle asynchronously.
  - Response: packet_out = 0, packet_valid = 0, in_ready = 1 immediately. The next 4 beats 0x55.. form 0x58575655 with no old lanes.
- Idle output and stats:
  - Stimulus: no input for 10 cycles with out_en = 1.
  - Response: packet_out = 0 and packet_valid = 0 on every cycle.
  - With LEAF_PACKER_STATS_EN: words_out increments once per emitted word; stall_cycles counts the 17th-beat stall in the full-FIFO scenario.
